// File: rtl/fifo_rd_packer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side packer.
//   state_t            : flush sequencing FSM encodings
//   DEFAULT_DATA_WIDTH : default width of one FIFO entry (one output lane)
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_rd_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer_if
// Packed-word output stream of the FIFO read-side packer.
//   m_data  : PACK lanes of DATA_WIDTH bits, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_keep  : lane-valid mask (all ones except on flush words)
//   m_last  : marks a word produced by a flush
//   m_valid : word valid
//   m_ready : downstream accept
// Modports: master (packer side), slave (consumer side).
// -----------------------------------------------------------------------------
interface fifo_rd_packer_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PACK       = 4
);

  logic [PACK*DATA_WIDTH-1:0] m_data;
  logic [PACK-1:0]            m_keep;
  logic                       m_last;
  logic                       m_valid;
  logic                       m_ready;

  modport master (
    output m_data,
    output m_keep,
    output m_last,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_keep,
    input  m_last,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/fifo_rd_packer_pack_out_reg.sv
// -----------------------------------------------------------------------------
// pack_out_reg
// Output holding register for the packer: one word with keep/last behind a
// valid/ready handshake. Contents are frozen while m_valid && !m_ready.
// Ports:
//   rd_clk, rst : clock, asynchronous active-high reset
//   load        : capture load_* into the register (only asserted when free)
//   load_data   : packed word to present
//   load_keep   : lane mask to present
//   load_last   : flush marker to present
//   free        : register can take a word this cycle (empty or being accepted)
//   m           : output stream (master side)
// -----------------------------------------------------------------------------
module pack_out_reg
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PACK       = 4
) (
  input  logic                       rd_clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [PACK*DATA_WIDTH-1:0] load_data,
  input  logic [PACK-1:0]            load_keep,
  input  logic                       load_last,
  output logic                       free,
  fifo_rd_packer_if.master           m
);

  logic [PACK*DATA_WIDTH-1:0] data_reg;
  logic [PACK-1:0]            keep_reg;
  logic                       last_reg;
  logic                       valid_reg;

  // A word being accepted this cycle frees the slot for a same-cycle reload.
  assign free = !valid_reg || m.m_ready;

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      keep_reg  <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      keep_reg  <= load_keep;
      last_reg  <= load_last;
      valid_reg <= 1'b1;
    end else if (m.m_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign m.m_data  = data_reg;
  assign m.m_keep  = keep_reg;
  assign m.m_last  = last_reg;
  assign m.m_valid = valid_reg;

endmodule

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
// Read-side drain stage of the asynchronous FIFO (rd_clk domain only).
// Pops entries, packs PACK of them into one word (first entry in lane 0) and
// presents the word on a valid/ready stream. A flush pulse emits any partial
// word with a lane mask and m_last, then pulses flush_done.
// Ports:
//   rd_clk      : sole clock
//   rst         : asynchronous active-high reset
//   fifo_rd     : pop request to the FIFO
//   fifo_empty  : FIFO empty flag
//   fifo_rdata  : FIFO read data, valid with fifo_valid
//   fifo_valid  : read data valid, one cycle after an accepted pop
//   flush       : pulse, emit whatever is accumulated
//   m           : packed output stream (m_data/m_keep/m_last/m_valid/m_ready)
//   flush_done  : one-cycle pulse once the flush has fully drained
//   proto_err   : sticky, fifo_valid seen with no pop in flight
// -----------------------------------------------------------------------------
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PACK       = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  output logic                  fifo_rd,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_valid,
  input  logic                  flush,
  fifo_rd_packer_if.master      m,
  output logic                  flush_done,
  output logic                  proto_err
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK - 1);

  state_t                             state_reg;
  logic                               flush_pend_reg;
  logic                               flush_done_reg;
  logic                               proto_err_reg;
  logic [CNT_W-1:0]                   cnt_reg;
  logic                               infl_reg;
  logic [PACK-1:0][DATA_WIDTH-1:0]    acc_reg;

  logic [CNT_W:0]                     occ;
  logic                               capture;
  logic                               cnt_full;
  logic                               handoff;
  logic                               flush_go;
  logic                               flush_emit;
  logic                               out_free;
  logic                               load;
  logic [PACK-1:0]                    lane_hit;
  logic [PACK-1:0]                    keep_flush;
  logic [PACK*DATA_WIDTH-1:0]         word;
  logic [PACK*DATA_WIDTH-1:0]         word_masked;

  // Lanes accumulated plus the one pop whose data is still on its way.
  assign occ      = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, infl_reg};
  assign fifo_rd  = !rst && !fifo_empty && !flush_pend_reg && (occ < (CNT_W+1)'(PACK));

  assign capture  = fifo_valid && infl_reg;
  assign cnt_full = (cnt_reg == CNT_FULL);

  // The pop rule keeps cnt+infl <= PACK, so capture never coincides with a
  // full accumulator. The last lane is forwarded straight into the output
  // register, giving one cycle from its fifo_valid to m_valid.
  assign handoff  = (cnt_full || (capture && (cnt_reg == CNT_LAST))) && out_free;

  // Flush resolves only once nothing is in flight and no full word is waiting;
  // a full word always leaves through the normal handoff first.
  assign flush_go   = (state_reg == S_FLUSH) && !infl_reg && out_free && !cnt_full;
  assign flush_emit = flush_go && (cnt_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < PACK; gi++) begin : g_lane
      assign lane_hit[gi]   = capture && (cnt_reg == CNT_W'(gi));
      assign keep_flush[gi] = (CNT_W'(gi) < cnt_reg);
      assign word[gi*DATA_WIDTH +: DATA_WIDTH] =
        lane_hit[gi] ? fifo_rdata : acc_reg[gi];
      assign word_masked[gi*DATA_WIDTH +: DATA_WIDTH] =
        keep_flush[gi] ? acc_reg[gi] : '0;
    end
  endgenerate

  assign load = handoff || flush_emit;

  pack_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK       (PACK)
  ) u_out (
    .rd_clk    (rd_clk),
    .rst       (rst),
    .load      (load),
    .load_data (flush_emit ? word_masked : word),
    .load_keep (flush_emit ? keep_flush : {PACK{1'b1}}),
    .load_last (flush_emit),
    .free      (out_free),
    .m         (m)
  );

  // Accumulator, lane counter, in-flight tracking and protocol check.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= '0;
      infl_reg      <= 1'b0;
      proto_err_reg <= 1'b0;
      acc_reg       <= '0;
    end else begin
      infl_reg <= fifo_rd;
      if (fifo_valid && !infl_reg) begin
        proto_err_reg <= 1'b1;
      end
      for (int i = 0; i < PACK; i++) begin
        if (lane_hit[i]) begin
          acc_reg[i] <= fifo_rdata;
        end
      end
      if (handoff || flush_go) begin
        cnt_reg <= '0;
      end else if (capture && !cnt_full) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Flush sequencing. flush_done is raised once the flush word (if any) has
  // been accepted, so it marks the stream as fully drained.
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_FILL;
      flush_pend_reg <= 1'b0;
      flush_done_reg <= 1'b0;
    end else begin
      flush_done_reg <= 1'b0;
      case (state_reg)
        S_FILL: begin
          if (flush) begin
            state_reg      <= S_FLUSH;
            flush_pend_reg <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_go) begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_free) begin
            flush_done_reg <= 1'b1;
            flush_pend_reg <= 1'b0;
            state_reg      <= S_FILL;
          end
        end
        default: begin
          state_reg <= S_FILL;
        end
      endcase
    end
  end

  assign flush_done = flush_done_reg;
  assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
// Directed bench for fifo_rd_packer: a FIFO model with one-cycle read latency,
// a table of word/flush vectors and hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int PACK  = 4;
  localparam int CNT_W = 3;

  logic          rd_clk = 1'b0;
  logic          rst    = 1'b1;
  logic          fifo_rd;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_valid;
  logic          flush = 1'b0;
  logic          flush_done;
  logic          proto_err;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PACK)) m_if ();

  fifo_rd_packer #(
    .DATA_WIDTH (DW),
    .PACK       (PACK),
    .CNT_W      (CNT_W)
  ) dut (
    .rd_clk     (rd_clk),
    .rst        (rst),
    .fifo_rd    (fifo_rd),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_valid (fifo_valid),
    .flush      (flush),
    .m          (m_if.master),
    .flush_done (flush_done),
    .proto_err  (proto_err)
  );

  // FIFO model: wp written by stimulus, rp by the model.
  logic [7:0] mem [512];
  int         wp = 0;
  int         rp = 0;
  logic       gate_empty   = 1'b0;
  logic       toggle_en    = 1'b0;
  logic       model_valid  = 1'b0;
  logic       inject_valid = 1'b0;
  logic       pop_req      = 1'b0;
  logic [7:0] model_rdata  = 8'h00;

  assign fifo_empty = (wp == rp) || gate_empty;
  assign fifo_rdata = model_rdata;
  assign fifo_valid = model_valid | inject_valid;

  always @(posedge rd_clk) begin
    if (pop_req) begin
      model_rdata <= mem[rp];
      rp          <= rp + 1;
      model_valid <= 1'b1;
    end else begin
      model_valid <= 1'b0;
    end
    gate_empty <= toggle_en ? ~gate_empty : 1'b0;
  end

  // Mid-cycle monitor: inputs only change just after posedge.
  int          pop_count  = 0;
  int          viol_count = 0;
  int          rx_count   = 0;
  logic [31:0] rx_data [64];
  logic [3:0]  rx_keep [64];
  logic        rx_last [64];

  always @(negedge rd_clk) begin
    pop_req = fifo_rd;
    if (fifo_rd) pop_count++;
    if (fifo_rd && fifo_empty) viol_count++;
    if (m_if.m_valid && m_if.m_ready) begin
      rx_data[rx_count] = m_if.m_data;
      rx_keep[rx_count] = m_if.m_keep;
      rx_last[rx_count] = m_if.m_last;
      rx_count++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp] = d;
    wp = wp + 1;
  endtask

  task automatic wait_pops(input int target, input string name);
    int budget;
    budget = 60;
    while ((pop_count < target) && (budget > 0)) begin
      step();
      budget--;
    end
    if (pop_count < target) check({name, " pop timeout"}, 32'(pop_count), 32'(target));
  endtask

  task automatic wait_rx(input int target, input int max_cycles, input string name);
    int budget;
    budget = max_cycles;
    while ((rx_count < target) && (budget > 0)) begin
      step();
      budget--;
    end
    if (rx_count < target) check({name, " word timeout"}, 32'(rx_count), 32'(target));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  typedef struct {
    int          n;         // entries pushed
    logic [31:0] seq;       // entries in pop order, first in the top byte
    logic        do_flush;
    logic [31:0] exp_data;  // compared on kept lanes only
    logic [3:0]  exp_keep;
    logic        exp_last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          p0;
    int          r0;
    int          hold_err;
    logic [31:0] s;
    logic [31:0] mask;
    logic [31:0] exp_w;
    logic [7:0]  ent [12];
    logic        done_seen;
    logic        valid_seen;

    vecs[0] = '{n:4, seq:32'h11223344, do_flush:1'b0, exp_data:32'h44332211, exp_keep:4'hF, exp_last:1'b0};
    vecs[1] = '{n:4, seq:32'hA55AFF00, do_flush:1'b0, exp_data:32'h00FF5AA5, exp_keep:4'hF, exp_last:1'b0};
    vecs[2] = '{n:2, seq:32'hAABB0000, do_flush:1'b1, exp_data:32'h0000BBAA, exp_keep:4'h3, exp_last:1'b1};
    vecs[3] = '{n:1, seq:32'h01000000, do_flush:1'b1, exp_data:32'h00000001, exp_keep:4'h1, exp_last:1'b1};
    vecs[4] = '{n:3, seq:32'h10203000, do_flush:1'b1, exp_data:32'h00302010, exp_keep:4'h7, exp_last:1'b1};
    vecs[5] = '{n:4, seq:32'hDEADBEEF, do_flush:1'b0, exp_data:32'hEFBEADDE, exp_keep:4'hF, exp_last:1'b0};

    m_if.m_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("reset m_valid",    32'(m_if.m_valid), 32'd0);
    check("reset m_data",     m_if.m_data,       32'd0);
    check("reset m_keep",     32'(m_if.m_keep),  32'd0);
    check("reset m_last",     32'(m_if.m_last),  32'd0);
    check("reset flush_done", 32'(flush_done),   32'd0);
    check("reset proto_err",  32'(proto_err),    32'd0);
    check("reset fifo_rd",    32'(fifo_rd),      32'd0);

    // Table of full-word and flush vectors, m_ready held high
    for (int v = 0; v < 6; v++) begin
      p0 = pop_count;
      r0 = rx_count;
      s  = vecs[v].seq;
      for (int i = 0; i < vecs[v].n; i++) push(s[31-8*i -: 8]);
      wait_pops(p0 + vecs[v].n, $sformatf("vec%0d", v));
      if (vecs[v].do_flush) begin
        step();
        step();
        pulse_flush();
      end
      wait_rx(r0 + 1, 40, $sformatf("vec%0d", v));
      // Acceptance edge has just passed: a flush must report done right now.
      check($sformatf("vec%0d flush_done", v), 32'(flush_done), 32'(vecs[v].do_flush));
      step();
      check($sformatf("vec%0d flush_done pulse", v), 32'(flush_done), 32'd0);
      for (int l = 0; l < 4; l++) mask[8*l +: 8] = {8{vecs[v].exp_keep[l]}};
      check($sformatf("vec%0d m_data", v), rx_data[r0] & mask, vecs[v].exp_data);
      check($sformatf("vec%0d m_keep", v), 32'(rx_keep[r0]), 32'(vecs[v].exp_keep));
      check($sformatf("vec%0d m_last", v), 32'(rx_last[r0]), 32'(vecs[v].exp_last));
      check($sformatf("vec%0d pops", v), 32'(pop_count - p0), 32'(vecs[v].n));
      step();
    end

    // Backpressure: 9 entries, m_ready low for 20 cycles
    m_if.m_ready = 1'b0;
    p0 = pop_count;
    r0 = rx_count;
    for (int i = 1; i <= 9; i++) push(8'(i));
    hold_err = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (m_if.m_valid && ((m_if.m_data !== 32'h04030201) || (m_if.m_keep !== 4'hF) || (m_if.m_last !== 1'b0)))
        hold_err++;
    end
    check("bp m_valid held",  32'(m_if.m_valid), 32'd1);
    check("bp m_data held",   m_if.m_data,       32'h04030201);
    check("bp hold stable",   32'(hold_err),     32'd0);
    check("bp pops stalled",  32'(pop_count - p0), 32'd8);
    check("bp none accepted", 32'(rx_count - r0),  32'd0);
    m_if.m_ready = 1'b1;
    wait_rx(r0 + 2, 40, "bp");
    check("bp word1", rx_data[r0],     32'h04030201);
    check("bp word2", rx_data[r0 + 1], 32'h08070605);
    wait_pops(p0 + 9, "bp tail");
    step();
    step();
    pulse_flush();
    wait_rx(r0 + 3, 40, "bp tail");
    check("bp tail lane0", rx_data[r0 + 2] & 32'h000000FF, 32'h00000009);
    check("bp tail keep",  32'(rx_keep[r0 + 2]), 32'h1);
    check("bp tail last",  32'(rx_last[r0 + 2]), 32'h1);
    for (int c = 0; c < 4; c++) step();

    // Flush with nothing accumulated and the FIFO empty
    r0 = rx_count;
    done_seen  = 1'b0;
    valid_seen = 1'b0;
    pulse_flush();
    for (int c = 0; c < 3; c++) begin
      step();
      if (flush_done) done_seen = 1'b1;
      if (m_if.m_valid) valid_seen = 1'b1;
    end
    check("empty flush done",     32'(done_seen),   32'd1);
    check("empty flush no valid", 32'(valid_seen),  32'd0);
    check("empty flush no word",  32'(rx_count - r0), 32'd0);
    step();

    // Gated empty flag with random backpressure
    toggle_en = 1'b1;
    p0 = pop_count;
    r0 = rx_count;
    for (int i = 0; i < 12; i++) begin
      ent[i] = 8'($urandom_range(0, 255));
      push(ent[i]);
    end
    for (int c = 0; (c < 400) && (rx_count < r0 + 3); c++) begin
      m_if.m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_if.m_ready = 1'b1;
    wait_rx(r0 + 3, 20, "stream");
    for (int w = 0; w < 3; w++) begin
      exp_w = {ent[4*w+3], ent[4*w+2], ent[4*w+1], ent[4*w]};
      check($sformatf("stream word%0d", w), rx_data[r0 + w], exp_w);
    end
    check("stream pops",       32'(pop_count - p0), 32'd12);
    check("stream words",      32'(rx_count - r0),  32'd3);
    check("no pop while empty", 32'(viol_count),    32'd0);
    toggle_en = 1'b0;
    step();
    step();
    check("proto_err quiet", 32'(proto_err), 32'd0);

    // Reset with cnt=2 and a pop in flight
    p0 = pop_count;
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    wait_pops(p0 + 3, "rst");
    rst = 1'b1;
    #1;
    check("rst m_valid",    32'(m_if.m_valid), 32'd0);
    check("rst m_data",     m_if.m_data,       32'd0);
    check("rst m_keep",     32'(m_if.m_keep),  32'd0);
    check("rst m_last",     32'(m_if.m_last),  32'd0);
    check("rst fifo_rd",    32'(fifo_rd),      32'd0);
    check("rst flush_done", 32'(flush_done),   32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("rst proto_err clear", 32'(proto_err), 32'd0);
    inject_valid = 1'b1;
    step();
    inject_valid = 1'b0;
    check("stale valid proto_err", 32'(proto_err),    32'd1);
    check("stale valid no word",   32'(m_if.m_valid), 32'd0);
    r0 = rx_count;
    for (int i = 1; i <= 4; i++) push(8'(8'h50 + i));
    wait_rx(r0 + 1, 40, "post rst");
    check("post rst word",     rx_data[r0], 32'h54535251);
    check("proto_err sticky",  32'(proto_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
